// File: rtl/dma_tl_arbiter_if.sv
// TileLink-UL bundle shared by the DMA channel cores, the channel arbiter and the
// system interconnect. Channel-side vectors are flattened, channel i at slice i.
interface dma_tl_arbiter_if #(
  parameter int NoC   = 2,
  parameter int TL_RS = 4,
  parameter int TL_AW = 32
);
  logic [3*NoC-1:0]     ca_opcode;
  logic [3*NoC-1:0]     ca_param;
  logic [4*NoC-1:0]     ca_size;
  logic [TL_AW*NoC-1:0] ca_address;
  logic [4*NoC-1:0]     ca_mask;
  logic [32*NoC-1:0]    ca_data;
  logic [NoC-1:0]       ca_corrupt;
  logic [NoC-1:0]       ca_valid;
  logic [NoC-1:0]       ca_ready;

  logic [3*NoC-1:0]     cd_opcode;
  logic [2*NoC-1:0]     cd_param;
  logic [4*NoC-1:0]     cd_size;
  logic [NoC-1:0]       cd_denied;
  logic [32*NoC-1:0]    cd_data;
  logic [NoC-1:0]       cd_corrupt;
  logic [NoC-1:0]       cd_valid;
  logic [NoC-1:0]       cd_ready;

  logic [2:0]           ma_opcode;
  logic [2:0]           ma_param;
  logic [3:0]           ma_size;
  logic [TL_RS-1:0]     ma_source;
  logic [TL_AW-1:0]     ma_address;
  logic [3:0]           ma_mask;
  logic [31:0]          ma_data;
  logic                 ma_corrupt;
  logic                 ma_valid;
  logic                 ma_ready;

  logic [2:0]           md_opcode;
  logic [1:0]           md_param;
  logic [3:0]           md_size;
  logic [TL_RS-1:0]     md_source;
  logic                 md_denied;
  logic [31:0]          md_data;
  logic                 md_corrupt;
  logic                 md_valid;
  logic                 md_ready;

  // Arbiter view: consumes channel A requests and master D responses
  modport slave (
    input  ca_opcode, ca_param, ca_size, ca_address, ca_mask, ca_data, ca_corrupt, ca_valid,
    output ca_ready,
    output cd_opcode, cd_param, cd_size, cd_denied, cd_data, cd_corrupt, cd_valid,
    input  cd_ready,
    output ma_opcode, ma_param, ma_size, ma_source, ma_address, ma_mask, ma_data, ma_corrupt,
    output ma_valid,
    input  ma_ready,
    input  md_opcode, md_param, md_size, md_source, md_denied, md_data, md_corrupt, md_valid,
    output md_ready
  );

  // Environment view: channel cores plus interconnect
  modport master (
    output ca_opcode, ca_param, ca_size, ca_address, ca_mask, ca_data, ca_corrupt, ca_valid,
    input  ca_ready,
    input  cd_opcode, cd_param, cd_size, cd_denied, cd_data, cd_corrupt, cd_valid,
    output cd_ready,
    input  ma_opcode, ma_param, ma_size, ma_source, ma_address, ma_mask, ma_data, ma_corrupt,
    input  ma_valid,
    output ma_ready,
    output md_opcode, md_param, md_size, md_source, md_denied, md_data, md_corrupt, md_valid,
    input  md_ready
  );
endinterface

// File: rtl/dma_tl_arbiter.sv
// Shares one TileLink-UL master port between NoC DMA channels: round-robin A arbitration
// with Put-burst locking, D routing by source. Define DMA_ARB_FIXED_PRIO_EN for fixed priority.
module dma_tl_arbiter #(
  parameter int NoC   = 2,
  parameter int TL_RS = 4,
  parameter int TL_AW = 32
) (
  input  logic            dma_clock_i,
  input  logic            dma_reset_ni,
  dma_tl_arbiter_if.slave bus,
  output logic            bad_src_o
);

  localparam int              IW       = (NoC > 1) ? $clog2(NoC) : 1;
  localparam logic [TL_RS:0]  NOC_LIM  = (TL_RS+1)'(NoC);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NoC - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e        state_r;
  logic [IW-1:0] lock_idx_r;
  logic [IW-1:0] hold_idx_r;
  logic          hold_vld_r;
  logic [15:0]   beats_left_r;
  logic          bad_src_r;

  logic [IW-1:0] arb_idx_s;
  logic          arb_hit_s;
  logic [IW-1:0] grant_s;
  logic [31:0]   gi_s;
  logic [IW-1:0] next_ptr_s;
  logic          ma_vld_s;
  logic          hs_s;
  logic          is_burst_s;
  logic [15:0]   burst_beats_s;
  logic [IW-1:0] d_idx_s;
  logic          src_ok_s;

`ifdef DMA_ARB_FIXED_PRIO_EN
  // Lowest-index requesting channel wins
  always_comb begin
    arb_idx_s = '0;
    arb_hit_s = 1'b0;
    for (int i = 0; i < NoC; i++) begin
      if (!arb_hit_s && bus.ca_valid[i]) begin
        arb_idx_s = IW'(i);
        arb_hit_s = 1'b1;
      end else begin
        arb_idx_s = arb_idx_s;
      end
    end
  end
`else
  logic [IW-1:0] ptr_r;

  // First requester at or after ptr, wrapping: search [ptr..NoC-1], then [0..NoC-1]
  always_comb begin
    arb_idx_s = '0;
    arb_hit_s = 1'b0;
    for (int i = 0; i < NoC; i++) begin
      if (!arb_hit_s && bus.ca_valid[i] && (IW'(i) >= ptr_r)) begin
        arb_idx_s = IW'(i);
        arb_hit_s = 1'b1;
      end else begin
        arb_idx_s = arb_idx_s;
      end
    end
    for (int i = 0; i < NoC; i++) begin
      if (!arb_hit_s && bus.ca_valid[i]) begin
        arb_idx_s = IW'(i);
        arb_hit_s = 1'b1;
      end else begin
        arb_idx_s = arb_idx_s;
      end
    end
  end
`endif

  // Grant selection: burst lock first, then a stalled offer, then fresh arbitration
  always_comb begin
    grant_s  = arb_idx_s;
    ma_vld_s = 1'b0;
    case (state_r)
      LOCKED: begin
        grant_s  = lock_idx_r;
        ma_vld_s = bus.ca_valid[lock_idx_r];
      end
      IDLE: begin
        if (hold_vld_r && bus.ca_valid[hold_idx_r]) begin
          grant_s = hold_idx_r;
        end else begin
          grant_s = arb_idx_s;
        end
        ma_vld_s = |bus.ca_valid;
      end
      default: begin
        grant_s  = arb_idx_s;
        ma_vld_s = 1'b0;
      end
    endcase
  end

  assign gi_s          = 32'(grant_s);
  assign hs_s          = ma_vld_s & bus.ma_ready & dma_reset_ni;
  assign next_ptr_s    = (grant_s == LAST_IDX) ? '0 : (grant_s + IW'(1));
  assign is_burst_s    = ((bus.ma_opcode == 3'd0) || (bus.ma_opcode == 3'd1)) && (bus.ma_size > 4'd2);
  assign burst_beats_s = (16'd1 << (bus.ma_size - 4'd2)) - 16'd1;

  // A-channel mux and per-channel ready; handshake-visible signals are held low in reset
  always_comb begin
    bus.ma_opcode  = bus.ca_opcode[3*gi_s +: 3];
    bus.ma_param   = bus.ca_param[3*gi_s +: 3];
    bus.ma_size    = bus.ca_size[4*gi_s +: 4];
    bus.ma_source  = TL_RS'(grant_s);
    bus.ma_address = bus.ca_address[TL_AW*gi_s +: TL_AW];
    bus.ma_mask    = bus.ca_mask[4*gi_s +: 4];
    bus.ma_data    = bus.ca_data[32*gi_s +: 32];
    bus.ma_corrupt = bus.ca_corrupt[grant_s];
    bus.ma_valid   = ma_vld_s & dma_reset_ni;
    bus.ca_ready   = '0;
    for (int i = 0; i < NoC; i++) begin
      bus.ca_ready[i] = dma_reset_ni & bus.ma_ready & (grant_s == IW'(i));
    end
  end

  assign d_idx_s  = bus.md_source[IW-1:0];
  assign src_ok_s = ({1'b0, bus.md_source} < NOC_LIM);

  // D-channel: payload broadcast, valid steered by source; unknown sources are sunk
  always_comb begin
    bus.cd_opcode  = {NoC{bus.md_opcode}};
    bus.cd_param   = {NoC{bus.md_param}};
    bus.cd_size    = {NoC{bus.md_size}};
    bus.cd_denied  = {NoC{bus.md_denied}};
    bus.cd_data    = {NoC{bus.md_data}};
    bus.cd_corrupt = {NoC{bus.md_corrupt}};
    bus.cd_valid   = '0;
    for (int i = 0; i < NoC; i++) begin
      bus.cd_valid[i] = dma_reset_ni & bus.md_valid & src_ok_s & (d_idx_s == IW'(i));
    end
    if (src_ok_s) begin
      bus.md_ready = dma_reset_ni & bus.cd_ready[d_idx_s];
    end else begin
      bus.md_ready = dma_reset_ni;
    end
  end

  // A-path state machine, stall hold, burst counter, ptr and bad-source pulse
  always_ff @(posedge dma_clock_i or negedge dma_reset_ni) begin
    if (!dma_reset_ni) begin
      state_r      <= IDLE;
      lock_idx_r   <= '0;
      hold_idx_r   <= '0;
      hold_vld_r   <= 1'b0;
      beats_left_r <= 16'd0;
      bad_src_r    <= 1'b0;
`ifndef DMA_ARB_FIXED_PRIO_EN
      ptr_r        <= '0;
`endif
    end else begin
      bad_src_r <= bus.md_valid & ~src_ok_s;
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            hold_vld_r <= 1'b0;
            if (is_burst_s) begin
              state_r      <= LOCKED;
              lock_idx_r   <= grant_s;
              beats_left_r <= burst_beats_s;
            end else begin
`ifndef DMA_ARB_FIXED_PRIO_EN
              ptr_r <= next_ptr_s;
`endif
            end
          end else if (ma_vld_s) begin
            hold_vld_r <= 1'b1;
            hold_idx_r <= grant_s;
          end else begin
            hold_vld_r <= 1'b0;
          end
        end
        LOCKED: begin
          if (hs_s) begin
            beats_left_r <= beats_left_r - 16'd1;
            if (beats_left_r == 16'd1) begin
              state_r <= IDLE;
`ifndef DMA_ARB_FIXED_PRIO_EN
              ptr_r   <= next_ptr_s;
`endif
            end else begin
              state_r <= LOCKED;
            end
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r    <= IDLE;
          hold_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign bad_src_o = bad_src_r;

endmodule

// File: doc/dma_tl_arbiter.md
Name: dma_tl_arbiter

Overview:
- Shares one TileLink-UL master port between NoC DMA channel engines.
- Sits between the per-channel A/D buses the DMA channel cores emit (flattened, channel i at slice i) and the system interconnect.
- Arbitrates A-channel requests round-robin and holds the grant for the full length of multi-beat Put bursts.
- Tags each request with its channel index on a_source and routes D-channel beats back to the originating channel by d_source.

Parameters:
- NoC, 2, number of channels; 1 <= NoC <= 2**TL_RS.
- TL_RS, 4, TileLink source width.
- TL_AW, 32, address width.

Ports:
- dma_clock_i  in  1  clock.
- dma_reset_ni  in  1  reset; asynchronous, active-low.
- ca_opcode  in  3*NoC  channel A opcode.
- ca_param  in  3*NoC  channel A param.
- ca_size  in  4*NoC  channel A log2 bytes.
- ca_address  in  TL_AW*NoC  channel A address.
- ca_mask  in  4*NoC  channel A byte mask.
- ca_data  in  32*NoC  channel A data.
- ca_corrupt  in  NoC  channel A corrupt.
- ca_valid  in  NoC  channel A valid.
- ca_ready  out  NoC  channel A ready.
- cd_opcode  out  3*NoC  channel D opcode.
- cd_param  out  2*NoC  channel D param.
- cd_size  out  4*NoC  channel D size.
- cd_denied  out  NoC  channel D denied.
- cd_data  out  32*NoC  channel D data.
- cd_corrupt  out  NoC  channel D corrupt.
- cd_valid  out  NoC  channel D valid.
- cd_ready  in  NoC  channel D ready.
- ma_opcode  out  3  master A opcode.
- ma_param  out  3  master A param.
- ma_size  out  4  master A size.
- ma_source  out  TL_RS  master A source.
- ma_address  out  TL_AW  master A address.
- ma_mask  out  4  master A mask.
- ma_data  out  32  master A data.
- ma_corrupt  out  1  master A corrupt.
- ma_valid  out  1  master A valid.
- ma_ready  in  1  master A ready.
- md_opcode  in  3  master D opcode.
- md_param  in  2  master D param.
- md_size  in  4  master D size.
- md_source  in  TL_RS  master D source.
- md_denied  in  1  master D denied.
- md_data  in  32  master D data.
- md_corrupt  in  1  master D corrupt.
- md_valid  in  1  master D valid.
- md_ready  out  1  master D ready.
- bad_src_o  out  1  one-cycle pulse when a D beat arrives with md_source >= NoC.

Behaviour:
- Reset (async assert, sync release):
  - ptr=0, state IDLE, beats_left=0, bad_src_o=0.
  - ma_valid, ca_ready, cd_valid all 0.
- A-path states:
  - IDLE:
    - grant = first requesting channel at or after ptr (wrapping).
    - The grant is combinational in the same cycle; zero added latency.
    - ma_* = granted channel's ca_*; ma_source = zero-extended grant index.
    - ma_valid = |ca_valid; only the granted channel's ca_ready follows ma_ready, all others 0.
  - On A handshake with opcode 0/1 (Put) and size > 2:
    - beats_left = (1<<(size-2)) - 1, stored grant index, go to LOCKED.
  - On any other handshake (Get=4, or Put with size <= 2): stay IDLE.
  - ptr = granted index + 1 mod NoC on every completed message (wraps NoC-1 -> 0).
  - LOCKED:
    - Grant forced to the stored index; other channels see ca_ready=0 even when valid.
    - beats_left decrements per handshake.
    - Handshake at beats_left==1 -> IDLE and ptr advance.
    - If the locked channel drops valid, ma_valid=0 and the lock is held.
  - The grant must not change while ma_valid=1 and ma_ready=0 (TL stability). Hold the selection in a register until handshake, even if a higher-priority channel asserts valid.
- D-path (combinational, independent of A-path):
  - idx = md_source[clog2(NoC)-1:0].
  - If md_source < NoC: cd_valid[idx] = md_valid, md_ready = cd_ready[idx].
  - cd_* payloads are broadcast to all channels; only cd_valid is per channel.
  - If md_source >= NoC: beat is sunk with md_ready=1, no cd_valid, bad_src_o pulses for each sunk beat (registered, 1 cycle later).
- Reset mid-burst: lock, ptr and counter clear immediately; no partial state is retained.
- NoC==1: ptr is constant 0; index widths are at least 1 bit.

Optional Feature:
- Macro DMA_ARB_FIXED_PRIO_EN.
- When defined: ptr is removed and the lowest-index valid channel always wins in IDLE. Burst locking and the hold-until-handshake rule are unchanged.
- When undefined: round-robin as above.

Test Plan:
- NoC=2, both channels Get size=2 continuously, ma_ready=1 -> ma_source alternates 0,1,0,1; each channel gets one grant per 2 cycles.
- ch1 PutFull size=4 (4 beats), ch0 valid from beat 2 onward -> ma_source=1 for 4 consecutive handshakes; ch0 ca_ready=0 throughout, then ch0 is granted next.
- ch0 valid with ma_ready=0 for 3 cycles, ch1 asserts in cycle 2 -> ma_* stays on ch0 payload until handshake; ch1 is granted next.
- md_source=1, md_valid=1, cd_ready=2'b01 -> cd_valid=2'b10 and md_ready=0; raise cd_ready[1] -> handshake.
- md_source=5 with NoC=2 -> md_ready=1, cd_valid=0, bad_src_o=1 one cycle later.
- Reset asserted during beat 2 of an 8-beat Put -> all outputs 0 asynchronously; after release the first request is granted from ch0.
